// File: rtl/calc_input_latch.sv
// calc_input_latch
// Front end for the 4-bit signed calculator. Raw DE2 switches and buttons
// are synchronized and the buttons are debounced. Buttons 0..2 toggle the
// pending operation bits. Button 3 (LOAD) commits the pending op and the
// switch operands into stable output registers.
//
// Ports
//   CLOCK_50    in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   KEY_N[3:0]  in   raw active-low buttons; [2:0] toggle op bits, [3] LOAD
//   SW[7:0]     in   raw switches; [7:4] operand A, [3:0] operand B
//   OP_PENDING  out  op bits being composed (LED display)
//   OP          out  committed op, feeds calculator KEY[2:0]
//   A, B        out  committed operands, feed calculator SW[7:0]
//   VALID       out  one-cycle pulse in the cycle after each commit
module calc_input_latch #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [3:0] KEY_N,
    input  logic [7:0] SW,
    output logic [2:0] OP_PENDING,
    output logic [2:0] OP,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       VALID
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    logic [3:0]    keyS1Q, keyS2Q;
    logic [7:0]    swS1Q, swS2Q;
    logic [3:0]    dbQ, dbD;
    logic [CW-1:0] cntQ [4];
    logic [CW-1:0] cntD [4];
    logic [3:0]    pressEv;
    logic [2:0]    opPendingQ, opPendingD;
    logic [2:0]    opQ;
    logic [3:0]    aQ, bQ;
    logic          validQ;
    logic          commit;
    state_t        stateQ, stateD;

    // Two-flop synchronizers. Buttons rest at the released level (1) so that
    // a reset never looks like a press; switches rest at 0.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            keyS1Q <= 4'hF;
            keyS2Q <= 4'hF;
            swS1Q  <= 8'h00;
            swS2Q  <= 8'h00;
        end else begin
            keyS1Q <= KEY_N;
            keyS2Q <= keyS1Q;
            swS1Q  <= SW;
            swS2Q  <= swS1Q;
        end
    end

    // Debouncers: a level change is accepted only after DEBOUNCE_CYCLES
    // consecutive differing samples. Any matching sample restarts the count,
    // and the count clears on the flip so it can never wrap. A press event is
    // the 1->0 flip, flagged in the same cycle the flip is decided.
    always_comb begin
        dbD     = dbQ;
        pressEv = '0;
        for (int i = 0; i < 4; i++) begin
            cntD[i] = cntQ[i];
            if (keyS2Q[i] == dbQ[i]) begin
                cntD[i] = '0;
            end else if (cntQ[i] == CNT_LAST) begin
                cntD[i]    = '0;
                dbD[i]     = ~dbQ[i];
                pressEv[i] = dbQ[i];
            end else begin
                cntD[i] = cntQ[i] + CW'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            dbQ <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                cntQ[i] <= '0;
            end
        end else begin
            dbQ <= dbD;
            for (int i = 0; i < 4; i++) begin
                cntQ[i] <= cntD[i];
            end
        end
    end

    // Each op button independently flips its pending bit on a press event;
    // simultaneous presses simply flip several bits at once.
    always_comb begin
        opPendingD = opPendingQ ^ pressEv[2:0];
    end

    // LOAD state machine: one commit per debounced press. After committing it
    // parks in HELD until the debounced LOAD level is released again.
    always_comb begin
        stateD = stateQ;
        commit = 1'b0;
        case (stateQ)
            IDLE: begin
                if (pressEv[3]) begin
                    commit = 1'b1;
                    stateD = HELD;
                end
            end
            HELD: begin
                if (dbQ[3]) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // State register, pending op, and the committed outputs. The commit takes
    // the next-state pending op so a toggle on the commit edge is included.
    // Switch operands pass through untouched; no arithmetic happens here.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stateQ     <= IDLE;
            opPendingQ <= 3'b000;
            opQ        <= 3'b000;
            aQ         <= 4'h0;
            bQ         <= 4'h0;
            validQ     <= 1'b0;
        end else begin
            stateQ     <= stateD;
            opPendingQ <= opPendingD;
            validQ     <= commit;
            if (commit) begin
                opQ <= opPendingD;
                aQ  <= swS2Q[7:4];
                bQ  <= swS2Q[3:0];
            end
        end
    end

    assign OP_PENDING = opPendingQ;
    assign OP         = opQ;
    assign A          = aQ;
    assign B          = bQ;
    assign VALID      = validQ;

endmodule

// File: tb/tb_calc_input_latch.sv
// Self-checking bench for calc_input_latch with DEBOUNCE_CYCLES = 4.
// Each expected commit is pushed to a scoreboard queue when the LOAD press
// is driven, together with the cycle in which VALID must be seen; a monitor
// pops and compares whenever VALID is high.
module tb_calc_input_latch;

    localparam int DB = 4;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        int         cyc;
    } expT;

    logic       clock;
    logic       resetN;
    logic [3:0] keyN;
    logic [7:0] sw;
    logic [2:0] opPending;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       valid;

    int  checkCount = 0;
    int  passCount  = 0;
    int  cycleCount = 0;
    int  validCount = 0;
    int  validBase;
    logic prevValid = 1'b0;
    expT expQ[$];

    calc_input_latch #(.DEBOUNCE_CYCLES(DB)) dut (
        .CLOCK_50   (clock),
        .RESET_N    (resetN),
        .KEY_N      (keyN),
        .SW         (sw),
        .OP_PENDING (opPending),
        .OP         (op),
        .A          (a),
        .B          (b),
        .VALID      (valid)
    );

    // Free-running clock and an edge counter used to time commits.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, observed, expected, cycleCount);
        end
    endtask

    // Drive the raw inputs just after a rising edge.
    task automatic applyStimulus(input logic [3:0] keys, input logic [7:0] sws);
        keyN = keys;
        sw   = sws;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Queue a commit expected from a LOAD press driven right now.
    task automatic expectCommit(input logic [2:0] eop, input logic [3:0] ea,
                                input logic [3:0] eb);
        expT e;
        e.op  = eop;
        e.a   = ea;
        e.b   = eb;
        e.cyc = cycleCount + 2 + DB;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: every VALID cycle must match the next queued commit
    // both in content and in timing, and VALID must never last two cycles.
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            validCount++;
            checkOutput("validWidth", 32'(prevValid), 32'(0));
            if (expQ.size() == 0) begin
                checkOutput("unexpectedValid", 32'(1), 32'(0));
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("commitOp", 32'(op), 32'(e.op));
                checkOutput("commitA", 32'(a), 32'(e.a));
                checkOutput("commitB", 32'(b), 32'(e.b));
                checkOutput("commitCycle", 32'(cycleCount), 32'(e.cyc));
            end
        end
        prevValid = valid;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        applyStimulus(4'hF, 8'h5A);

        // Reset state
        waitCycles(3);
        @(negedge clock);
        checkOutput("rstOpPending", 32'(opPending), 32'(0));
        checkOutput("rstOp", 32'(op), 32'(0));
        checkOutput("rstA", 32'(a), 32'(0));
        checkOutput("rstB", 32'(b), 32'(0));
        checkOutput("rstValid", 32'(valid), 32'(0));
        @(posedge clock);
        #1;
        resetN = 1'b1;
        waitCycles(20);
        checkOutput("idleOp", 32'(op), 32'(0));
        checkOutput("idleValidCount", 32'(validCount), 32'(0));

        // Toggle op bit 0, then commit with SW = 0x52
        applyStimulus(4'hE, 8'h5A);
        waitCycles(10);
        applyStimulus(4'hF, 8'h5A);
        waitCycles(10);
        checkOutput("toggle0Pending", 32'(opPending), 32'(1));
        checkOutput("toggle0OpHeld", 32'(op), 32'(0));
        applyStimulus(4'hF, 8'h52);
        waitCycles(3);
        validBase = validCount;
        applyStimulus(4'h7, 8'h52);
        expectCommit(3'b001, 4'h5, 4'h2);
        waitCycles(10);
        applyStimulus(4'hF, 8'h52);
        waitCycles(10);
        checkOutput("load1Count", 32'(validCount - validBase), 32'(1));

        // Glitch rejection on button 1, then a real press
        applyStimulus(4'hD, 8'h52);
        waitCycles(3);
        applyStimulus(4'hF, 8'h52);
        waitCycles(10);
        checkOutput("glitchPending", 32'(opPending), 32'(1));
        applyStimulus(4'hD, 8'h52);
        waitCycles(6);
        applyStimulus(4'hF, 8'h52);
        waitCycles(10);
        checkOutput("toggle1Pending", 32'(opPending), 32'(3));

        // LOAD held for 50 cycles with switches changing mid-hold
        applyStimulus(4'hF, 8'h71);
        waitCycles(3);
        validBase = validCount;
        applyStimulus(4'h7, 8'h71);
        expectCommit(3'b011, 4'h7, 4'h1);
        waitCycles(20);
        applyStimulus(4'h7, 8'h9F);
        waitCycles(30);
        applyStimulus(4'hF, 8'h9F);
        waitCycles(10);
        checkOutput("heldCount", 32'(validCount - validBase), 32'(1));
        checkOutput("heldA", 32'(a), 32'(7));
        checkOutput("heldB", 32'(b), 32'(1));

        // Clear pending bits 0 and 1 together, then toggle bit 2 with LOAD
        applyStimulus(4'hC, 8'h9F);
        waitCycles(6);
        applyStimulus(4'hF, 8'h9F);
        waitCycles(10);
        checkOutput("clearPending", 32'(opPending), 32'(0));
        applyStimulus(4'h3, 8'h9F);
        expectCommit(3'b100, 4'h9, 4'hF);
        repeat (5) @(posedge clock);
        @(negedge clock);
        checkOutput("simPendingBefore", 32'(opPending), 32'(0));
        @(posedge clock);
        @(negedge clock);
        checkOutput("simPendingAfter", 32'(opPending), 32'(4));
        checkOutput("simOp", 32'(op), 32'(4));
        @(posedge clock);
        #1;
        waitCycles(8);
        applyStimulus(4'hF, 8'h9F);
        waitCycles(10);

        // Reset two cycles into a LOAD press, button held through release
        validBase = validCount;
        applyStimulus(4'h7, 8'h9F);
        waitCycles(2);
        resetN = 1'b0;
        waitCycles(2);
        @(negedge clock);
        checkOutput("midRstOp", 32'(op), 32'(0));
        checkOutput("midRstPending", 32'(opPending), 32'(0));
        checkOutput("midRstA", 32'(a), 32'(0));
        checkOutput("midRstValidCount", 32'(validCount - validBase), 32'(0));
        @(posedge clock);
        #1;
        resetN = 1'b1;
        expectCommit(3'b000, 4'h9, 4'hF);
        waitCycles(12);
        applyStimulus(4'hF, 8'h9F);
        waitCycles(10);
        checkOutput("postRstCount", 32'(validCount - validBase), 32'(1));

        checkOutput("pendingCommits", 32'(expQ.size()), 32'(0));
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
